// File: rtl/ex1_b_demux.sv
// rtl/ex1_b_demux.sv - 1-to-5 routed demux with a 2-entry FIFO per output channel
// Select bits steer each accepted word into one channel queue; back-pressure is the only overflow mechanism.

module ex1_b_demux_ch #(
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rdy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  vld,
  output logic                  full
);

  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;

  assign pop  = vld & rdy;
  assign vld  = (count != 2'd0);
  assign full = (count == 2'd2);
  assign dout = head;

  // Only the occupancy count is reset; entry contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: count <= count + 2'd1;
        2'b01: count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
        end
        2'b01: head <= tail;
        2'b11: begin
          // At count 1 the pushed word replaces the departing head directly.
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: begin
          head <= head;
          tail <= tail;
        end
      endcase
    end
  end

endmodule

module ex1_b_demux #(
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s2,
  input  logic                  s1,
  input  logic                  s0,
  input  logic [DATA_WIDTH-1:0] M,
  input  logic                  M_vld,
  output logic                  M_rdy,
  output logic [DATA_WIDTH-1:0] U,
  output logic [DATA_WIDTH-1:0] V,
  output logic [DATA_WIDTH-1:0] W,
  output logic [DATA_WIDTH-1:0] X,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  U_vld,
  output logic                  V_vld,
  output logic                  W_vld,
  output logic                  X_vld,
  output logic                  Y_vld,
  input  logic                  U_rdy,
  input  logic                  V_rdy,
  input  logic                  W_rdy,
  input  logic                  X_rdy,
  input  logic                  Y_rdy,
  output logic [7:0]            acc_cnt
);

  logic [4:0]            sel_oh;
  logic [4:0]            push;
  logic [4:0]            full;
  logic [4:0]            vld;
  logic [4:0]            rdy;
  logic [DATA_WIDTH-1:0] dout [5];
  logic                  accept;

  // Channel order in the vectors: 0=U, 1=V, 2=W, 3=X, 4=Y.
  always_comb begin
    sel_oh = 5'b00000;
    if (s2) sel_oh[4] = 1'b1;
    else    sel_oh[{s1, s0}] = 1'b1;
  end

  // Ready depends only on target occupancy, never on the consumer's ready.
  assign M_rdy  = !rst_n || !(|(sel_oh & full));
  assign accept = M_vld && M_rdy && rst_n;
  assign push   = sel_oh & {5{accept}};
  assign rdy    = {Y_rdy, X_rdy, W_rdy, V_rdy, U_rdy};

  for (genvar c = 0; c < 5; c++) begin : g_ch
    ex1_b_demux_ch #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[c]),
      .din  (M),
      .rdy  (rdy[c]),
      .dout (dout[c]),
      .vld  (vld[c]),
      .full (full[c])
    );
  end

  assign U = dout[0];
  assign V = dout[1];
  assign W = dout[2];
  assign X = dout[3];
  assign Y = dout[4];

  assign U_vld = vld[0];
  assign V_vld = vld[1];
  assign W_vld = vld[2];
  assign X_vld = vld[3];
  assign Y_vld = vld[4];

  always_ff @(posedge clk) begin
    if (!rst_n)      acc_cnt <= 8'd0;
    else if (accept) acc_cnt <= acc_cnt + 8'd1;
  end

endmodule

// File: tb/tb_ex1_b_demux.sv
// tb/tb_ex1_b_demux.sv - table-driven bench for ex1_b_demux plus a counter-wrap sequence

module tb_ex1_b_demux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s2, s1, s0;
  logic [2:0] M;
  logic       M_vld;
  logic       M_rdy;
  logic [2:0] U, V, W, X, Y;
  logic       U_vld, V_vld, W_vld, X_vld, Y_vld;
  logic       U_rdy, V_rdy, W_rdy, X_rdy, Y_rdy;
  logic [7:0] acc_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex1_b_demux #(.DATA_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .s2(s2), .s1(s1), .s0(s0),
    .M(M), .M_vld(M_vld), .M_rdy(M_rdy),
    .U(U), .V(V), .W(W), .X(X), .Y(Y),
    .U_vld(U_vld), .V_vld(V_vld), .W_vld(W_vld), .X_vld(X_vld), .Y_vld(Y_vld),
    .U_rdy(U_rdy), .V_rdy(V_rdy), .W_rdy(W_rdy), .X_rdy(X_rdy), .Y_rdy(Y_rdy),
    .acc_cnt(acc_cnt)
  );

  logic [4:0] vld_v;
  logic [2:0] dout [5];
  assign vld_v   = {Y_vld, X_vld, W_vld, V_vld, U_vld};
  assign dout[0] = U;
  assign dout[1] = V;
  assign dout[2] = W;
  assign dout[3] = X;
  assign dout[4] = Y;

  typedef struct {
    logic        rst_n;
    logic [2:0]  sel;
    logic [2:0]  m;
    logic        m_vld;
    logic [4:0]  rdy;
    logic        exp_mrdy;
    logic [4:0]  exp_vld;
    logic [14:0] exp_d;
    logic [7:0]  exp_acc;
  } vec_t;

  vec_t tbl [30];
  logic [4:0] prev_vld;
  logic       prev_ok;

  function automatic vec_t mk(input logic r, input logic [2:0] sel, input logic [2:0] m,
                              input logic mv, input logic [4:0] rdy, input logic emr,
                              input logic [4:0] ev, input logic [2:0] u, input logic [2:0] v,
                              input logic [2:0] w, input logic [2:0] x, input logic [2:0] y,
                              input logic [7:0] acc);
    vec_t t;
    t.rst_n = r; t.sel = sel; t.m = m; t.m_vld = mv; t.rdy = rdy;
    t.exp_mrdy = emr; t.exp_vld = ev; t.exp_d = {y, x, w, v, u}; t.exp_acc = acc;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] sel, input logic [2:0] m,
                       input logic mv, input logic [4:0] rdy);
    rst_n = r;
    {s2, s1, s0} = sel;
    M = m;
    M_vld = mv;
    {Y_rdy, X_rdy, W_rdy, V_rdy, U_rdy} = rdy;
  endtask

  task automatic apply(input int idx, input vec_t t);
    @(negedge clk);
    drive(t.rst_n, t.sel, t.m, t.m_vld, t.rdy);
    #1;
    if (t.m_vld || !t.rst_n)
      check($sformatf("v%0d M_rdy", idx), int'(M_rdy), int'(t.exp_mrdy));
    // Outputs must not move before the edge: no same-cycle bypass.
    if (prev_ok)
      check($sformatf("v%0d pre-edge vld", idx), int'(vld_v), int'(prev_vld));
    @(posedge clk);
    #1;
    check($sformatf("v%0d vld", idx), int'(vld_v), int'(t.exp_vld));
    check($sformatf("v%0d acc_cnt", idx), int'(acc_cnt), int'(t.exp_acc));
    for (int c = 0; c < 5; c++)
      if (t.exp_vld[c])
        check($sformatf("v%0d data ch%0d", idx, c), int'(dout[c]), int'(t.exp_d[c*3 +: 3]));
    prev_vld = t.exp_vld;
    prev_ok  = 1'b1;
  endtask

  initial begin
    int accepted;
    int cyc;
    logic took;

    drive(1'b0, 3'b000, 3'd0, 1'b0, 5'b00000);
    prev_ok  = 1'b0;
    prev_vld = 5'b00000;

    //          rst sel     m     mv  rdy       mrdy vld       U     V     W     X     Y     acc
    tbl[0]  = mk(0, 3'b000, 3'd7, 1, 5'b00000, 1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0);
    tbl[1]  = mk(1, 3'b000, 3'd5, 1, 5'b00000, 1, 5'b00001, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 8'd1);
    tbl[2]  = mk(1, 3'b001, 3'd5, 1, 5'b00000, 1, 5'b00011, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 8'd2);
    tbl[3]  = mk(1, 3'b010, 3'd5, 1, 5'b00000, 1, 5'b00111, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0, 8'd3);
    tbl[4]  = mk(1, 3'b011, 3'd5, 1, 5'b00000, 1, 5'b01111, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 8'd4);
    tbl[5]  = mk(1, 3'b100, 3'd5, 1, 5'b00000, 1, 5'b11111, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 8'd5);
    tbl[6]  = mk(1, 3'b000, 3'd0, 0, 5'b11111, 1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd5);
    tbl[7]  = mk(1, 3'b111, 3'd2, 1, 5'b00000, 1, 5'b10000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 8'd6);
    tbl[8]  = mk(1, 3'b000, 3'd0, 0, 5'b10000, 1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd6);
    tbl[9]  = mk(1, 3'b010, 3'd1, 1, 5'b00000, 1, 5'b00100, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 8'd7);
    tbl[10] = mk(1, 3'b010, 3'd2, 1, 5'b00000, 1, 5'b00100, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 8'd8);
    tbl[11] = mk(1, 3'b010, 3'd3, 1, 5'b00000, 0, 5'b00100, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 8'd8);
    tbl[12] = mk(1, 3'b010, 3'd3, 1, 5'b00100, 0, 5'b00100, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 8'd8);
    tbl[13] = mk(1, 3'b010, 3'd3, 1, 5'b00100, 1, 5'b00100, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 8'd9);
    tbl[14] = mk(1, 3'b010, 3'd0, 0, 5'b00100, 1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd9);
    tbl[15] = mk(1, 3'b001, 3'd4, 1, 5'b00000, 1, 5'b00010, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 8'd10);
    tbl[16] = mk(1, 3'b001, 3'd6, 1, 5'b00010, 1, 5'b00010, 3'd0, 3'd6, 3'd0, 3'd0, 3'd0, 8'd11);
    tbl[17] = mk(1, 3'b001, 3'd0, 0, 5'b11111, 1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd11);
    tbl[18] = mk(1, 3'b000, 3'd1, 1, 5'b00000, 1, 5'b00001, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 8'd12);
    tbl[19] = mk(1, 3'b000, 3'd2, 1, 5'b00000, 1, 5'b00001, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 8'd13);
    tbl[20] = mk(1, 3'b011, 3'd3, 1, 5'b00000, 1, 5'b01001, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 8'd14);
    tbl[21] = mk(1, 3'b011, 3'd4, 1, 5'b00000, 1, 5'b01001, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 8'd15);
    tbl[22] = mk(1, 3'b000, 3'd7, 1, 5'b00000, 0, 5'b01001, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 8'd15);
    tbl[23] = mk(0, 3'b000, 3'd7, 1, 5'b00000, 1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0);
    tbl[24] = mk(1, 3'b000, 3'd1, 1, 5'b00000, 1, 5'b00001, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 8'd1);
    tbl[25] = mk(1, 3'b000, 3'd2, 1, 5'b00000, 1, 5'b00001, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 8'd2);
    tbl[26] = mk(1, 3'b011, 3'd3, 1, 5'b00000, 1, 5'b01001, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 8'd3);
    tbl[27] = mk(1, 3'b011, 3'd4, 1, 5'b00000, 1, 5'b01001, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 8'd4);
    tbl[28] = mk(1, 3'b000, 3'd0, 0, 5'b01001, 1, 5'b01001, 3'd2, 3'd0, 3'd0, 3'd4, 3'd0, 8'd4);
    tbl[29] = mk(1, 3'b000, 3'd0, 0, 5'b01001, 1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd4);

    for (int i = 0; i < 30; i++) apply(i, tbl[i]);

    // Counter wrap: stream 256 words through Y with the consumer always ready.
    apply(100, mk(0, 3'b000, 3'd0, 0, 5'b00000, 1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0));
    accepted = 0;
    cyc = 0;
    while (accepted < 256 && cyc < 400) begin
      @(negedge clk);
      drive(1'b1, 3'b100, accepted[2:0], 1'b1, 5'b10000);
      #1;
      took = M_rdy;
      @(posedge clk);
      #1;
      if (took) accepted++;
      cyc++;
      if (took && accepted == 255) check("wrap acc_cnt at 255", int'(acc_cnt), 255);
    end
    if (accepted != 256) begin
      check("wrap accept timeout", accepted, 256);
    end else begin
      check("wrap acc_cnt", int'(acc_cnt), 0);
      check("wrap Y_vld", int'(Y_vld), 1);
      check("wrap Y last word", int'(Y), 7);
    end
    @(negedge clk);
    drive(1'b1, 3'b000, 3'd0, 1'b0, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex1_b_demux.md
EX1_B_DEMUX -- requirements
Module: ex1_b_demux

Interface
REQ-001 Parameter DATA_WIDTH, default 3: width of the routed data word.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 s2  input  1  route select MSB; 1 selects channel Y regardless of s1/s0.
REQ-005 s1  input  1  route select; with s2=0 selects pair {U,V} (0) or {W,X} (1).
REQ-006 s0  input  1  route select LSB; with s2=0 selects first (0) or second (1) of the pair.
REQ-007 M  input  DATA_WIDTH  inbound data word.
REQ-008 M_vld  input  1  inbound word valid.
REQ-009 M_rdy  output  1  inbound word accepted when M_vld and M_rdy are both 1.
REQ-010 U, V, W, X, Y  output  DATA_WIDTH each  per-channel head-of-queue data.
REQ-011 U_vld, V_vld, W_vld, X_vld, Y_vld  output  1 each  per-channel data valid.
REQ-012 U_rdy, V_rdy, W_rdy, X_rdy, Y_rdy  input  1 each  per-channel consumer ready; a pop occurs when <ch>_vld and <ch>_rdy are both 1.
REQ-013 acc_cnt  output  8  count of accepted inbound words, wraps 255->0.

Function
REQ-014 Decode SHALL be: s2=1 -> Y; s2s1s0=000 -> U; 001 -> V; 010 -> W; 011 -> X.
REQ-015 s2, s1, s0, M SHALL be sampled only in a cycle where M_vld=1; they are don't-care otherwise.
REQ-016 Each channel SHALL hold a 2-entry FIFO with a 2-bit occupancy count (0..2).
REQ-017 M_rdy SHALL be combinational: 1 when the decoded target channel count < 2, else 0; M_rdy SHALL NOT depend on the target's <ch>_rdy (no full-pass-through).
REQ-018 An accepted word SHALL be written to the tail of the decoded channel only; other channels are unaffected.
REQ-019 <ch>_vld SHALL equal (count != 0); <ch> data SHALL equal the head entry, and the head entry value while count == 0 is don't-care.
REQ-020 Latency: a word accepted at edge k SHALL appear with <ch>_vld=1 after edge k (one cycle minimum); no same-cycle bypass from M to any channel output.
REQ-021 Per-channel word order SHALL be preserved (FIFO); no ordering is guaranteed across channels.
REQ-022 Simultaneous push and pop on the same channel with count=1 SHALL leave count=1 and present the pushed word as the new head.
REQ-023 Push on count=0 -> 1; pop on count=1 without push -> 0; pop on count=2 -> 1 with second entry promoted to head.
REQ-024 Pops on different channels in the same cycle SHALL all be honoured independently.
REQ-025 <ch>_rdy asserted while <ch>_vld=0 SHALL have no effect.
REQ-026 acc_cnt SHALL increment by 1 on every accepted inbound word, modulo 256.
REQ-027 No word SHALL be dropped or duplicated; back-pressure is the only overflow mechanism.

Reset
REQ-028 With rst_n=0 at a rising edge, all channel counts SHALL become 0, all <ch>_vld SHALL be 0, and acc_cnt SHALL be 0 after that edge.
REQ-029 Reset SHALL take priority over any push or pop in the same cycle; words in flight or queued SHALL be discarded.
REQ-030 During reset M_rdy SHALL reflect empty FIFOs (1) but no word SHALL be accepted while rst_n=0.

Verification
REQ-031 Routing: after reset push M=3'd5 with s2s1s0=000,001,010,011,100 on consecutive cycles, all <ch>_rdy=0 -> U,V,W,X,Y each hold 5 with vld=1, acc_cnt=5.
REQ-032 Y override: push M=3'd2 with s2s1s0=111 -> only Y_vld rises, Y=2; U..X_vld stay 0.
REQ-033 Back-pressure: push 1,2,3 to W with W_rdy=0 -> third cycle M_rdy=0, W=1, count 2; raise W_rdy -> W shows 1 then 2, then M_rdy=1 and 3 is accepted.
REQ-034 Push+pop at count=1: V holds 4, same cycle push 6 to V with V_rdy=1 -> next cycle V=6, V_vld=1, count 1.
REQ-035 Wrap: 256 accepted words -> acc_cnt returns to 0.
REQ-036 Reset mid-operation: U and X full, assert rst_n=0 for one edge with M_vld=1 -> all vld=0, acc_cnt=0, no word accepted.
